// File: rtl/msrv32_pc_mux.sv
// rtl/msrv32_pc_mux.sv - next-PC selection and registered instruction fetch address
module msrv32_pc_mux #(
  parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        branch_taken_in,
  input  logic        ahb_ready_in,
  input  logic [1:0]  pc_src_in,
  input  logic [31:0] epc_in,
  input  logic [31:0] trap_address_in,
  input  logic [31:0] pc_in,
  input  logic [31:1] iaddr_in,
  output logic [31:0] iaddr_out,
  output logic [31:0] pc_plus_4_out,
  output logic        misaligned_instr_logic_out,
  output logic [31:0] pc_mux_out
);

  localparam logic [1:0] SRC_BOOT = 2'b00;
  localparam logic [1:0] SRC_EPC  = 2'b01;
  localparam logic [1:0] SRC_TRAP = 2'b10;
  localparam logic [1:0] SRC_NEXT = 2'b11;

  logic [31:0] next_pc;

  assign pc_plus_4_out = pc_in + 32'd4;

  // Bit 0 of the jump target is always cleared; bit 1 set means a non-word target.
  assign next_pc                    = branch_taken_in ? {iaddr_in[31:1], 1'b0} : pc_plus_4_out;
  assign misaligned_instr_logic_out = branch_taken_in & next_pc[1];

  always_comb begin
    pc_mux_out = BOOT_ADDRESS;
    if (rst_in) begin
      case (pc_src_in)
        SRC_BOOT: pc_mux_out = BOOT_ADDRESS;
        SRC_EPC:  pc_mux_out = epc_in;
        SRC_TRAP: pc_mux_out = trap_address_in;
        SRC_NEXT: pc_mux_out = next_pc;
        default:  pc_mux_out = BOOT_ADDRESS;
      endcase
    end
  end

  // Fetch address only advances when the instruction bus accepts it.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      iaddr_out <= BOOT_ADDRESS;
    end else if (ahb_ready_in) begin
      iaddr_out <= pc_mux_out;
    end
  end

endmodule

// File: tb/tb_msrv32_pc_mux.sv
// tb/tb_msrv32_pc_mux.sv - self-checking bench for msrv32_pc_mux
module tb_msrv32_pc_mux;

  logic        clk_in;
  logic        rst_in;
  logic        branch_taken_in;
  logic        ahb_ready_in;
  logic [1:0]  pc_src_in;
  logic [31:0] epc_in;
  logic [31:0] trap_address_in;
  logic [31:0] pc_in;
  logic [31:1] iaddr_in;
  logic [31:0] iaddr_out;
  logic [31:0] pc_plus_4_out;
  logic        misaligned_instr_logic_out;
  logic [31:0] pc_mux_out;

  int checks = 0;
  int passed = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_val;
  logic [31:0] model_iaddr;

  msrv32_pc_mux dut (
    .clk_in                     (clk_in),
    .rst_in                     (rst_in),
    .branch_taken_in            (branch_taken_in),
    .ahb_ready_in               (ahb_ready_in),
    .pc_src_in                  (pc_src_in),
    .epc_in                     (epc_in),
    .trap_address_in            (trap_address_in),
    .pc_in                      (pc_in),
    .iaddr_in                   (iaddr_in),
    .iaddr_out                  (iaddr_out),
    .pc_plus_4_out              (pc_plus_4_out),
    .misaligned_instr_logic_out (misaligned_instr_logic_out),
    .pc_mux_out                 (pc_mux_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [31:0] ref_mux(input logic [1:0] src, input logic br,
                                          input logic [31:0] pc, input logic [31:1] tgt,
                                          input logic [31:0] epc, input logic [31:0] trap);
    logic [31:0] seq;
    seq = pc + 32'd4;
    case (src)
      2'b00:   return 32'h0;
      2'b01:   return epc;
      2'b10:   return trap;
      default: return br ? {tgt, 1'b0} : seq;
    endcase
  endfunction

  task automatic test_reset();
    rst_in = 1'b1; ahb_ready_in = 1'b1; branch_taken_in = 1'b1;
    pc_src_in = 2'b10; trap_address_in = 32'h11223344; epc_in = 32'hAABBCCDD;
    pc_in = 32'h0000_0100; iaddr_in = 31'h0000_0801;
    #2;
    rst_in = 1'b0;
    #1;
    checks++;
    if (pc_mux_out !== 32'h0) $display("FAIL reset_pc_mux: got %h want %h", pc_mux_out, 32'h0);
    else passed++;
    checks++;
    if (iaddr_out !== 32'h0) $display("FAIL reset_iaddr: got %h want %h", iaddr_out, 32'h0);
    else passed++;
    checks++;
    if (pc_plus_4_out !== 32'h0000_0104) $display("FAIL reset_pc_plus_4: got %h want %h", pc_plus_4_out, 32'h0000_0104);
    else passed++;
    checks++;
    if (misaligned_instr_logic_out !== 1'b1) $display("FAIL reset_misaligned: got %b want 1", misaligned_instr_logic_out);
    else passed++;
    exp_q.push_back(32'h0);
    tick();
    exp_val = exp_q.pop_front();
    checks++;
    if (iaddr_out !== exp_val) $display("FAIL reset_hold_edge: got %h want %h", iaddr_out, exp_val);
    else passed++;
    rst_in = 1'b1;
    model_iaddr = 32'h0;
  endtask

  task automatic test_source_select();
    logic [31:0] want [4];
    want = '{32'h0, 32'hAABBCCDD, 32'h11223344, 32'h4};
    branch_taken_in = 1'b0; ahb_ready_in = 1'b1; pc_in = 32'h0;
    for (int i = 0; i < 4; i++) begin
      pc_src_in = 2'(i);
      #1;
      checks++;
      if (pc_mux_out !== want[i]) $display("FAIL src_sel_%0d_pc_mux: got %h want %h", i, pc_mux_out, want[i]);
      else passed++;
      exp_q.push_back(want[i]);
      tick();
      exp_val = exp_q.pop_front();
      checks++;
      if (iaddr_out !== exp_val) $display("FAIL src_sel_%0d_iaddr: got %h want %h", i, iaddr_out, exp_val);
      else passed++;
    end
  endtask

  task automatic test_branch();
    pc_src_in = 2'b11; branch_taken_in = 1'b1; ahb_ready_in = 1'b1;
    iaddr_in = 31'h0000_0801;
    #1;
    checks++;
    if (pc_mux_out !== 32'h0000_1002) $display("FAIL branch_odd_pc_mux: got %h want %h", pc_mux_out, 32'h0000_1002);
    else passed++;
    checks++;
    if (misaligned_instr_logic_out !== 1'b1) $display("FAIL branch_odd_misaligned: got %b want 1", misaligned_instr_logic_out);
    else passed++;
    exp_q.push_back(32'h0000_1002);
    tick();
    exp_val = exp_q.pop_front();
    checks++;
    if (iaddr_out !== exp_val) $display("FAIL branch_odd_iaddr: got %h want %h", iaddr_out, exp_val);
    else passed++;
    iaddr_in = 31'h0000_0800;
    #1;
    checks++;
    if (pc_mux_out !== 32'h0000_1000) $display("FAIL branch_even_pc_mux: got %h want %h", pc_mux_out, 32'h0000_1000);
    else passed++;
    checks++;
    if (misaligned_instr_logic_out !== 1'b0) $display("FAIL branch_even_misaligned: got %b want 0", misaligned_instr_logic_out);
    else passed++;
    pc_src_in = 2'b01; iaddr_in = 31'h0000_0801;
    #1;
    checks++;
    if (pc_mux_out !== 32'hAABBCCDD) $display("FAIL branch_ignored_pc_mux: got %h want %h", pc_mux_out, 32'hAABBCCDD);
    else passed++;
    checks++;
    if (misaligned_instr_logic_out !== 1'b1) $display("FAIL branch_ignored_misaligned: got %b want 1", misaligned_instr_logic_out);
    else passed++;
    branch_taken_in = 1'b0;
  endtask

  task automatic test_stall();
    pc_src_in = 2'b11; branch_taken_in = 1'b0; pc_in = 32'h0; ahb_ready_in = 1'b1;
    exp_q.push_back(32'h4);
    tick();
    exp_val = exp_q.pop_front();
    checks++;
    if (iaddr_out !== exp_val) $display("FAIL stall_setup_iaddr: got %h want %h", iaddr_out, exp_val);
    else passed++;
    ahb_ready_in = 1'b0; pc_src_in = 2'b01;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(32'h4);
      tick();
      exp_val = exp_q.pop_front();
      checks++;
      if (iaddr_out !== exp_val) $display("FAIL stall_hold_%0d: got %h want %h", i, iaddr_out, exp_val);
      else passed++;
    end
    ahb_ready_in = 1'b1;
    exp_q.push_back(32'hAABBCCDD);
    tick();
    exp_val = exp_q.pop_front();
    checks++;
    if (iaddr_out !== exp_val) $display("FAIL stall_release_iaddr: got %h want %h", iaddr_out, exp_val);
    else passed++;
  endtask

  task automatic test_wrap();
    pc_in = 32'hFFFF_FFFC; pc_src_in = 2'b11; branch_taken_in = 1'b0; ahb_ready_in = 1'b1;
    #1;
    checks++;
    if (pc_plus_4_out !== 32'h0) $display("FAIL wrap_pc_plus_4: got %h want %h", pc_plus_4_out, 32'h0);
    else passed++;
    checks++;
    if (pc_mux_out !== 32'h0) $display("FAIL wrap_pc_mux: got %h want %h", pc_mux_out, 32'h0);
    else passed++;
    exp_q.push_back(32'h0);
    tick();
    exp_val = exp_q.pop_front();
    checks++;
    if (iaddr_out !== exp_val) $display("FAIL wrap_iaddr: got %h want %h", iaddr_out, exp_val);
    else passed++;
  endtask

  task automatic test_reset_mid_stall();
    pc_src_in = 2'b10; ahb_ready_in = 1'b1;
    exp_q.push_back(32'h11223344);
    tick();
    exp_val = exp_q.pop_front();
    checks++;
    if (iaddr_out !== exp_val) $display("FAIL mid_stall_setup: got %h want %h", iaddr_out, exp_val);
    else passed++;
    ahb_ready_in = 1'b0;
    rst_in = 1'b0;
    #1;
    checks++;
    if (iaddr_out !== 32'h0) $display("FAIL mid_stall_async: got %h want %h", iaddr_out, 32'h0);
    else passed++;
    rst_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(32'h0);
      tick();
      exp_val = exp_q.pop_front();
      checks++;
      if (iaddr_out !== exp_val) $display("FAIL mid_stall_hold_%0d: got %h want %h", i, iaddr_out, exp_val);
      else passed++;
    end
    ahb_ready_in = 1'b1;
    exp_q.push_back(32'h11223344);
    tick();
    exp_val = exp_q.pop_front();
    checks++;
    if (iaddr_out !== exp_val) $display("FAIL mid_stall_first_ready: got %h want %h", iaddr_out, exp_val);
    else passed++;
    model_iaddr = 32'h11223344;
  endtask

  task automatic test_back_to_back();
    logic [31:0] m;
    for (int i = 0; i < 24; i++) begin
      pc_src_in       = 2'($urandom_range(0, 3));
      branch_taken_in = 1'($urandom_range(0, 1));
      ahb_ready_in    = ($urandom_range(0, 3) != 0);
      pc_in           = $urandom & 32'hFFFF_FFFC;
      iaddr_in        = 31'($urandom);
      epc_in          = $urandom;
      trap_address_in = $urandom;
      m = ref_mux(pc_src_in, branch_taken_in, pc_in, iaddr_in, epc_in, trap_address_in);
      #1;
      checks++;
      if (pc_mux_out !== m) $display("FAIL b2b_%0d_pc_mux: got %h want %h", i, pc_mux_out, m);
      else passed++;
      if (ahb_ready_in) model_iaddr = m;
      exp_q.push_back(model_iaddr);
      tick();
      exp_val = exp_q.pop_front();
      checks++;
      if (iaddr_out !== exp_val) $display("FAIL b2b_%0d_iaddr: got %h want %h", i, iaddr_out, exp_val);
      else passed++;
    end
  endtask

  initial begin
    model_iaddr = 32'h0;
    test_reset();
    test_source_select();
    test_branch();
    test_stall();
    test_wrap();
    test_reset_mid_stall();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
